// File: rtl/decode_stage.sv
// RV32I decode stage: full instruction decode, 32x32 register file with
// write-through bypass, immediate generation, ID/EX register and load-use stall.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_pipe_PC,
  input  logic [31:0] i_pipe_Instruction,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_load_use_stall,
  output logic        o_pipe_valid,
  output logic        o_pipe_illegal,
  output logic [31:0] o_pipe_PC,
  output logic [31:0] o_pipe_rs1_data,
  output logic [31:0] o_pipe_rs2_data,
  output logic [31:0] o_pipe_imm,
  output logic [4:0]  o_pipe_rs1,
  output logic [4:0]  o_pipe_rs2,
  output logic [4:0]  o_pipe_rd,
  output logic [3:0]  o_pipe_alu_op,
  output logic [2:0]  o_pipe_funct3,
  output logic        o_pipe_alu_src_pc,
  output logic        o_pipe_alu_src_imm,
  output logic        o_pipe_reg_we,
  output logic        o_pipe_mem_re,
  output logic        o_pipe_mem_we,
  output logic        o_pipe_branch,
  output logic        o_pipe_jump,
  output logic        o_pipe_jalr,
  output logic [1:0]  o_pipe_wb_sel
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        alu_src_pc;
    logic        alu_src_imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [1:0]  wb_sel;
  } idex_t;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  idex_t       idex_q, idex_d, dec;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic        illegal, uses_rs1, uses_rs2;

  assign opcode = i_pipe_Instruction[6:0];
  assign rd     = i_pipe_Instruction[11:7];
  assign funct3 = i_pipe_Instruction[14:12];
  assign rs1    = i_pipe_Instruction[19:15];
  assign rs2    = i_pipe_Instruction[24:20];
  assign funct7 = i_pipe_Instruction[31:25];

  assign imm_i = {{20{i_pipe_Instruction[31]}}, i_pipe_Instruction[31:20]};
  assign imm_s = {{20{i_pipe_Instruction[31]}}, i_pipe_Instruction[31:25],
                  i_pipe_Instruction[11:7]};
  assign imm_b = {{19{i_pipe_Instruction[31]}}, i_pipe_Instruction[31], i_pipe_Instruction[7],
                  i_pipe_Instruction[30:25], i_pipe_Instruction[11:8], 1'b0};
  assign imm_u = {i_pipe_Instruction[31:12], 12'h000};
  assign imm_j = {{11{i_pipe_Instruction[31]}}, i_pipe_Instruction[31], i_pipe_Instruction[19:12],
                  i_pipe_Instruction[20], i_pipe_Instruction[30:21], 1'b0};

  always_comb begin
    regs_d = regs_q;
    if (i_wb_we && (i_wb_rd != 5'd0)) regs_d[i_wb_rd] = i_wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Same-cycle writeback is forwarded so the value is seen before the write lands.
  always_comb begin
    rs1_data = regs_q[rs1];
    if (rs1 == 5'd0) rs1_data = '0;
    else if (i_wb_we && (i_wb_rd == rs1)) rs1_data = i_wb_data;
    rs2_data = regs_q[rs2];
    if (rs2 == 5'd0) rs2_data = '0;
    else if (i_wb_we && (i_wb_rd == rs2)) rs2_data = i_wb_data;
  end

  always_comb begin
    dec          = '0;
    illegal      = 1'b0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    dec.pc       = i_pipe_PC;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.funct3   = funct3;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    case (opcode)
      OPC_LUI: begin
        dec.imm = imm_u; dec.alu_op = ALU_PASS_B; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.alu_op = ALU_ADD; dec.alu_src_pc = 1'b1;
        dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.alu_op = ALU_ADD; dec.alu_src_pc = 1'b1; dec.alu_src_imm = 1'b1;
        dec.reg_we = 1'b1; dec.jump = 1'b1; dec.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        uses_rs1 = 1'b1;
        dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1;
        dec.reg_we = 1'b1; dec.jalr = 1'b1; dec.wb_sel = WB_PC4;
        illegal = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
        illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1;
        dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1;
        dec.reg_we = 1'b1; dec.mem_re = 1'b1; dec.wb_sel = WB_MEM;
        illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.imm = imm_s; dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1; dec.mem_we = 1'b1;
        illegal = (funct3 > 3'd2);
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
        dec.alu_op = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
        if (funct3 == 3'd1) illegal = (funct7 != 7'h00);
        else if (funct3 == 3'd5) illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.reg_we = 1'b1;
        dec.alu_op = alu_of(funct3, funct7[5]);
        illegal = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      default: illegal = 1'b1;
    endcase
    dec.valid   = 1'b1;
    dec.illegal = illegal;
    if (illegal) begin
      dec.reg_we = 1'b0; dec.mem_re = 1'b0; dec.mem_we = 1'b0;
      dec.branch = 1'b0; dec.jump   = 1'b0; dec.jalr   = 1'b0;
    end
    // The all-zero word is what fetch emits out of reset: treat it as an empty slot.
    if (i_pipe_Instruction == '0) dec = '0;
  end

  assign o_load_use_stall = idex_q.valid & idex_q.mem_re & (idex_q.rd != 5'd0) &
                            dec.valid & ~dec.illegal &
                            ((uses_rs1 & (rs1 == idex_q.rd)) | (uses_rs2 & (rs2 == idex_q.rd)));

  always_comb begin
    idex_d = dec;
    if (i_pipe_flush)          idex_d = '0;
    else if (i_pipe_stall)     idex_d = idex_q;
    else if (o_load_use_stall) idex_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q    <= '0;
      idex_q.pc <= RESET_PC;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign o_pipe_valid       = idex_q.valid;
  assign o_pipe_illegal     = idex_q.illegal;
  assign o_pipe_PC          = idex_q.pc;
  assign o_pipe_rs1_data    = idex_q.rs1_data;
  assign o_pipe_rs2_data    = idex_q.rs2_data;
  assign o_pipe_imm         = idex_q.imm;
  assign o_pipe_rs1         = idex_q.rs1;
  assign o_pipe_rs2         = idex_q.rs2;
  assign o_pipe_rd          = idex_q.rd;
  assign o_pipe_alu_op      = idex_q.alu_op;
  assign o_pipe_funct3      = idex_q.funct3;
  assign o_pipe_alu_src_pc  = idex_q.alu_src_pc;
  assign o_pipe_alu_src_imm = idex_q.alu_src_imm;
  assign o_pipe_reg_we      = idex_q.reg_we;
  assign o_pipe_mem_re      = idex_q.mem_re;
  assign o_pipe_mem_we      = idex_q.mem_we;
  assign o_pipe_branch      = idex_q.branch;
  assign o_pipe_jump        = idex_q.jump;
  assign o_pipe_jalr        = idex_q.jalr;
  assign o_pipe_wb_sel      = idex_q.wb_sel;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expectations are queued when an instruction
// is presented and compared one edge later against the ID/EX outputs.
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk, reset;
  logic        i_pipe_stall, i_pipe_flush, i_wb_we;
  logic [31:0] i_pipe_PC, i_pipe_Instruction, i_wb_data;
  logic [4:0]  i_wb_rd;
  logic        o_load_use_stall, o_pipe_valid, o_pipe_illegal;
  logic [31:0] o_pipe_PC, o_pipe_rs1_data, o_pipe_rs2_data, o_pipe_imm;
  logic [4:0]  o_pipe_rs1, o_pipe_rs2, o_pipe_rd;
  logic [3:0]  o_pipe_alu_op;
  logic [2:0]  o_pipe_funct3;
  logic        o_pipe_alu_src_pc, o_pipe_alu_src_imm, o_pipe_reg_we, o_pipe_mem_re;
  logic        o_pipe_mem_we, o_pipe_branch, o_pipe_jump, o_pipe_jalr;
  logic [1:0]  o_pipe_wb_sel;

  decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
    .i_pipe_PC(i_pipe_PC), .i_pipe_Instruction(i_pipe_Instruction),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_load_use_stall(o_load_use_stall),
    .o_pipe_valid(o_pipe_valid), .o_pipe_illegal(o_pipe_illegal),
    .o_pipe_PC(o_pipe_PC), .o_pipe_rs1_data(o_pipe_rs1_data),
    .o_pipe_rs2_data(o_pipe_rs2_data), .o_pipe_imm(o_pipe_imm),
    .o_pipe_rs1(o_pipe_rs1), .o_pipe_rs2(o_pipe_rs2), .o_pipe_rd(o_pipe_rd),
    .o_pipe_alu_op(o_pipe_alu_op), .o_pipe_funct3(o_pipe_funct3),
    .o_pipe_alu_src_pc(o_pipe_alu_src_pc), .o_pipe_alu_src_imm(o_pipe_alu_src_imm),
    .o_pipe_reg_we(o_pipe_reg_we), .o_pipe_mem_re(o_pipe_mem_re),
    .o_pipe_mem_we(o_pipe_mem_we), .o_pipe_branch(o_pipe_branch),
    .o_pipe_jump(o_pipe_jump), .o_pipe_jalr(o_pipe_jalr),
    .o_pipe_wb_sel(o_pipe_wb_sel)
  );

  typedef struct packed {
    logic        valid, illegal, reg_we, mem_re, mem_we, branch, jump, jalr;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic        src_pc, src_imm;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, rs1_data, rs2_data, pc;
  } pipe_t;

  typedef struct packed { pipe_t v; pipe_t m; } sb_t;

  sb_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic pipe_t sample();
    pipe_t p;
    p.valid = o_pipe_valid;     p.illegal = o_pipe_illegal;   p.reg_we = o_pipe_reg_we;
    p.mem_re = o_pipe_mem_re;   p.mem_we = o_pipe_mem_we;     p.branch = o_pipe_branch;
    p.jump = o_pipe_jump;       p.jalr = o_pipe_jalr;         p.wb_sel = o_pipe_wb_sel;
    p.alu_op = o_pipe_alu_op;   p.src_pc = o_pipe_alu_src_pc; p.src_imm = o_pipe_alu_src_imm;
    p.funct3 = o_pipe_funct3;   p.rd = o_pipe_rd;             p.rs1 = o_pipe_rs1;
    p.rs2 = o_pipe_rs2;         p.imm = o_pipe_imm;           p.rs1_data = o_pipe_rs1_data;
    p.rs2_data = o_pipe_rs2_data; p.pc = o_pipe_PC;
    return p;
  endfunction

  task automatic push(input pipe_t v, input pipe_t m);
    sb_t s;
    s.v = v;
    s.m = m;
    exp_q.push_back(s);
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr);
    i_pipe_PC          = pc;
    i_pipe_Instruction = instr;
  endtask

  task automatic test_reset();
    pipe_t e, m, got;
    sb_t   s;
    e = '0; e.pc = RST_PC; m = '1;
    push(e, m);
    #1;
    got = sample(); n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL reset_state: scoreboard empty"); end
    else begin
      s = exp_q.pop_front();
      if (((got ^ s.v) & s.m) !== '0) begin
        n_err++; $display("FAIL reset_state: got %h required %h care %h", got, s.v, s.m);
      end
    end
    n_cmp++;
    if (o_load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b required 0", o_load_use_stall);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    pipe_t e, m, got;
    sb_t   s;
    e = '0; e.valid = 1; e.reg_we = 1; e.rd = 6; e.rs1 = 5; e.rs2 = 5;
    e.rs1_data = 32'hDEAD_BEEF; e.rs2_data = 32'hDEAD_BEEF;
    m = '1; m.imm = '0;
    i_wb_rd = 5'd5; i_wb_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      i_wb_we = (k == 0);
      present(32'h200 + 32'(4 * k), 32'h0052_8333);
      e.pc = 32'h200 + 32'(4 * k);
      push(e, m);
      @(posedge clk); #1;
      got = sample(); n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL add_x5_%0d: scoreboard empty", k); end
      else begin
        s = exp_q.pop_front();
        if (((got ^ s.v) & s.m) !== '0) begin
          n_err++; $display("FAIL add_x5_%0d: got %h required %h care %h", k, got, s.v, s.m);
        end
      end
    end
    i_wb_we = 1'b0;
  endtask

  task automatic test_branch_jal();
    pipe_t e, m, got;
    sb_t   s;
    for (int k = 0; k < 2; k++) begin
      e = '0; m = '1;
      if (k == 0) begin
        present(32'h300, 32'hFE20_8CE3);
        e.valid = 1; e.branch = 1; e.alu_op = 4'd1; e.rd = 5'd25; e.rs1 = 1; e.rs2 = 2;
        e.imm = 32'hFFFF_FFF8; e.pc = 32'h300;
        m.wb_sel = '0;
      end else begin
        present(32'h304, 32'h0010_00EF);
        e.valid = 1; e.reg_we = 1; e.jump = 1; e.wb_sel = 2'd2; e.src_pc = 1; e.src_imm = 1;
        e.rd = 1; e.imm = 32'h0000_0800; e.pc = 32'h304;
        m.alu_op = '0; m.rs1 = '0; m.rs2 = '0; m.rs1_data = '0; m.rs2_data = '0;
      end
      push(e, m);
      @(posedge clk); #1;
      got = sample(); n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL beq_jal_%0d: scoreboard empty", k); end
      else begin
        s = exp_q.pop_front();
        if (((got ^ s.v) & s.m) !== '0) begin
          n_err++; $display("FAIL beq_jal_%0d: got %h required %h care %h", k, got, s.v, s.m);
        end
      end
    end
  endtask

  task automatic test_load_use();
    pipe_t e, m, got;
    sb_t   s;
    logic  stall_exp;
    for (int k = 0; k < 5; k++) begin
      e = '0; m = '1; stall_exp = 1'b0;
      e.pc = 32'h400 + 32'(4 * k);
      case (k)
        0, 3: begin
          present(e.pc, 32'h0000_A383);
          e.valid = 1; e.reg_we = 1; e.mem_re = 1; e.wb_sel = 2'd1; e.src_imm = 1;
          e.funct3 = 3'd2; e.rd = 7; e.rs1 = 1;
          m.rs2 = '0; m.rs2_data = '0;
        end
        1: begin
          present(e.pc, 32'h0003_8433);
          stall_exp = 1'b1;
          e.pc = '0;
        end
        2: begin
          e.pc = 32'h404;
          present(e.pc, 32'h0003_8433);
          e.valid = 1; e.reg_we = 1; e.rd = 8; e.rs1 = 7;
          m.imm = '0;
        end
        default: begin
          present(e.pc, 32'h0010_0413);
          e.valid = 1; e.reg_we = 1; e.src_imm = 1; e.rd = 8; e.imm = 32'd1;
          m.rs2 = '0; m.rs2_data = '0;
        end
      endcase
      #1;
      n_cmp++;
      if (o_load_use_stall !== stall_exp) begin
        n_err++;
        $display("FAIL load_use_stall_%0d: got %b required %b", k, o_load_use_stall, stall_exp);
      end
      push(e, m);
      @(posedge clk); #1;
      got = sample(); n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL load_use_%0d: scoreboard empty", k); end
      else begin
        s = exp_q.pop_front();
        if (((got ^ s.v) & s.m) !== '0) begin
          n_err++; $display("FAIL load_use_%0d: got %h required %h care %h", k, got, s.v, s.m);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] instr_t [6] = '{32'hFFFF_FFFF, 32'h4020_9033, 32'h0000_3003,
                                 32'h0000_2063, 32'h0000_0000, 32'h4020_D1B3};
    logic [2:0]  flags_t [6] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b000, 3'b101};
    pipe_t e, m, got;
    sb_t   s;
    for (int k = 0; k < 6; k++) begin
      present(32'h500 + 32'(4 * k), instr_t[k]);
      e = '0; m = '0;
      {e.valid, e.illegal, e.reg_we} = flags_t[k];
      {m.valid, m.illegal, m.reg_we, m.mem_re, m.mem_we, m.branch, m.jump, m.jalr} = '1;
      if (k == 5) begin e.alu_op = 4'd7; m.alu_op = '1; end
      push(e, m);
      @(posedge clk); #1;
      got = sample(); n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL illegal_%0d: scoreboard empty", k); end
      else begin
        s = exp_q.pop_front();
        if (((got ^ s.v) & s.m) !== '0) begin
          n_err++; $display("FAIL illegal_%0d: got %h required %h care %h", k, got, s.v, s.m);
        end
      end
    end
  endtask

  task automatic test_flush_stall();
    logic [31:0] junk_t [3] = '{32'h0052_8333, 32'hFFFF_FFFF, 32'h0000_A383};
    pipe_t e, m, hold, got;
    sb_t   s;
    hold = '0; hold.valid = 1; hold.reg_we = 1; hold.src_imm = 1; hold.rd = 9;
    hold.imm = 32'd5; hold.pc = 32'h608;
    m = '1; m.rs2 = '0; m.rs2_data = '0;
    for (int k = 0; k < 6; k++) begin
      i_pipe_flush = 1'b0; i_pipe_stall = 1'b0;
      e = hold;
      if (k == 0) begin
        present(32'h600, 32'h0050_0493); e.pc = 32'h600;
      end else if (k == 1) begin
        present(32'h604, 32'h0052_8333); i_pipe_flush = 1'b1; i_pipe_stall = 1'b1; e = '0;
      end else if (k == 2) begin
        present(32'h608, 32'h0050_0493);
      end else begin
        present(32'h700 + 32'(16 * k), junk_t[k-3]); i_pipe_stall = 1'b1;
      end
      push(e, (k == 1) ? '1 : m);
      @(posedge clk); #1;
      got = sample(); n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL flush_stall_%0d: scoreboard empty", k); end
      else begin
        s = exp_q.pop_front();
        if (((got ^ s.v) & s.m) !== '0) begin
          n_err++; $display("FAIL flush_stall_%0d: got %h required %h care %h", k, got, s.v, s.m);
        end
      end
    end
    i_pipe_flush = 1'b0; i_pipe_stall = 1'b0;
  endtask

  task automatic test_x0();
    pipe_t e, m, got;
    sb_t   s;
    e = '0; e.valid = 1; e.reg_we = 1; e.rd = 10;
    m = '1; m.imm = '0;
    i_wb_rd = 5'd0; i_wb_data = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      i_wb_we = (k == 0);
      present(32'h800 + 32'(4 * k), 32'h0000_0533);
      e.pc = 32'h800 + 32'(4 * k);
      push(e, m);
      @(posedge clk); #1;
      got = sample(); n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL x0_read_%0d: scoreboard empty", k); end
      else begin
        s = exp_q.pop_front();
        if (((got ^ s.v) & s.m) !== '0) begin
          n_err++; $display("FAIL x0_read_%0d: got %h required %h care %h", k, got, s.v, s.m);
        end
      end
    end
    i_wb_we = 1'b0;
  endtask

  task automatic test_reset_midstream();
    pipe_t e, m, got;
    sb_t   s;
    i_wb_rd = 5'd5; i_wb_data = 32'hCAFE_0001;
    for (int k = 0; k < 3; k++) begin
      e = '0; e.valid = 1; e.reg_we = 1; e.rd = 6; e.rs1 = 5; e.rs2 = 5;
      m = '1; m.imm = '0;
      if (k == 0) begin
        i_wb_we = 1'b1;
        present(32'h900, 32'h0052_8333);
        e.pc = 32'h900; e.rs1_data = 32'hCAFE_0001; e.rs2_data = 32'hCAFE_0001;
        push(e, m);
        @(posedge clk); #1;
        i_wb_we = 1'b0;
      end else if (k == 1) begin
        #2 reset = 1'b1;
        #1;
        e = '0; e.pc = RST_PC;
        push(e, '1);
      end else begin
        present(32'h904, 32'h0052_8333);
        e.pc = 32'h904;
        push(e, m);
        @(posedge clk); #1;
      end
      got = sample(); n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL mid_reset_%0d: scoreboard empty", k); end
      else begin
        s = exp_q.pop_front();
        if (((got ^ s.v) & s.m) !== '0) begin
          n_err++; $display("FAIL mid_reset_%0d: got %h required %h care %h", k, got, s.v, s.m);
        end
      end
      if (k == 1) begin
        n_cmp++;
        if (o_load_use_stall !== 1'b0) begin
          n_err++; $display("FAIL mid_reset_stall: got %b required 0", o_load_use_stall);
        end
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_pipe_stall = 1'b0; i_pipe_flush = 1'b0;
    i_pipe_PC = '0; i_pipe_Instruction = '0;
    i_wb_we = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    test_reset();
    test_bypass();
    test_branch_jal();
    test_load_use();
    test_illegal();
    test_flush_stall();
    test_x0();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
